uart_reg_ctrl: RTL and testbench

Command sequencer between the UART receiver/transmitter and the on-chip register bank. It turns the received byte stream into register accesses: a write is an address byte followed by a data byte, and a read is a single address byte. It issues the register write or read strobes, and for a read it returns the data byte through the UART transmitter. It sits in impl_top between the UART RX/TX cores and the register file driving the LEDs and RGBs.

---
 rtl/uart_reg_ctrl_if.sv | 47 ++++
 rtl/uart_reg_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_uart_reg_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_reg_ctrl_if
// Bundles the UART RX/TX handshake and the register-bank access bus that the
// uart_reg_ctrl command sequencer sits between.
//
// Signals:
//   uart_rx_valid  one-cycle pulse, uart_rx_data holds a received byte
//   uart_rx_data   received byte
//   uart_tx_busy   UART TX is serialising a byte
//   uart_tx_en     one-cycle pulse, start transmitting uart_tx_data
//   uart_tx_data   byte to transmit
//   reg_addr       register address of the current access
//   reg_wdata      register write data
//   reg_wr_en      one-cycle write strobe
//   reg_rd_en      one-cycle read strobe
//   reg_rdata      read data, qualified by reg_rd_valid
//   reg_rd_valid   one-cycle pulse, reg_rdata is valid
//
// Modports:
//   master  the sequencer (drives strobes, address, TX byte)
//   slave   the UART cores plus register file around it
// -----------------------------------------------------------------------------
interface uart_reg_ctrl_if #(
   parameter int ADDR_W = 7
);
   logic              uart_rx_valid;
   logic [7:0]        uart_rx_data;
   logic              uart_tx_busy;
   logic              uart_tx_en;
   logic [7:0]        uart_tx_data;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_wr_en;
   logic              reg_rd_en;
   logic [7:0]        reg_rdata;
   logic              reg_rd_valid;

   modport master (
      input  uart_rx_valid, uart_rx_data, uart_tx_busy, reg_rdata, reg_rd_valid,
      output uart_tx_en, uart_tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en
   );

   modport slave (
      output uart_rx_valid, uart_rx_data, uart_tx_busy, reg_rdata, reg_rd_valid,
      input  uart_tx_en, uart_tx_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en
   );
endinterface

// File: rtl/uart_reg_ctrl.sv
// -----------------------------------------------------------------------------
// uart_reg_ctrl
// Command sequencer between the UART cores and the register bank.
//   write : address byte with bit7=1, followed by a data byte
//   read  : address byte with bit7=0; the read data is sent back over UART TX
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   bus          uart_reg_ctrl_if.master (UART RX/TX + register access bus)
//   busy         high in every state except IDLE
//   err_timeout  one-cycle pulse when an access is aborted by timeout
//   err_overrun  one-cycle pulse when a received byte is dropped
//
// All outputs are registered. The FSM is split into a state/output register
// process, a next-state process and a next-output process.
// -----------------------------------------------------------------------------
module uart_reg_ctrl #(
   parameter int CLK_HZ         = 50000000,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int ADDR_W         = 7
) (
   input  logic              clk,
   input  logic              resetn,
   uart_reg_ctrl_if.master   bus,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_overrun
);

   if (CLK_HZ <= 0 || TIMEOUT_CYCLES < 2 || ADDR_W != 7) begin : g_bad_param
      $error("uart_reg_ctrl: illegal parameter value");
   end

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DATA,
      S_WRITE,
      S_READ_REQ,
      S_READ_WAIT,
      S_TX_SEND,
      S_TX_WAIT
   } state_t;

   state_t            state;
   state_t            nxt_state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_n;
   logic              expired;

   logic              tx_en_n;
   logic [7:0]        tx_data_n;
   logic [ADDR_W-1:0] addr_n;
   logic [7:0]        wdata_n;
   logic              wr_en_n;
   logic              rd_en_n;
   logic              busy_n;
   logic              err_timeout_n;
   logic              err_overrun_n;

   // Saturating increment: the timeout counter must never wrap back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= CNT_MAX) ? v : v + 1'b1;
   endfunction

   // The counter holds the number of cycles already spent in the current
   // state, so this cycle is the TIMEOUT_CYCLES-th one when it reads CNT_LAST.
   assign expired = (cnt >= CNT_LAST);

   // Next-state logic
   always_comb begin
      nxt_state = state;
      unique case (state)
         S_IDLE: begin
            if (bus.uart_rx_valid) begin
               nxt_state = bus.uart_rx_data[7] ? S_WAIT_DATA : S_READ_REQ;
            end
         end
         S_WAIT_DATA: begin
            // A byte arriving on the expiry cycle still wins.
            if (bus.uart_rx_valid) begin
               nxt_state = S_WRITE;
            end else if (expired) begin
               nxt_state = S_IDLE;
            end
         end
         S_WRITE: nxt_state = S_IDLE;
         S_READ_REQ: begin
            // Zero-latency register file answers in the strobe cycle itself.
            nxt_state = bus.reg_rd_valid ? S_TX_SEND : S_READ_WAIT;
         end
         S_READ_WAIT: begin
            if (bus.reg_rd_valid) begin
               nxt_state = S_TX_SEND;
            end else if (expired) begin
               nxt_state = S_IDLE;
            end
         end
         S_TX_SEND: begin
            if (!bus.uart_tx_busy) begin
               nxt_state = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            // uart_tx_en is still high in the first TX_WAIT cycle; TX raises
            // busy one cycle late, so busy is ignored while the strobe is up.
            if (!bus.uart_tx_en && !bus.uart_tx_busy) begin
               nxt_state = S_IDLE;
            end
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   // Next-output logic (values loaded into the output registers)
   always_comb begin
      cnt_n         = (nxt_state == state) ? sat_inc(cnt) : '0;
      addr_n        = bus.reg_addr;
      wdata_n       = bus.reg_wdata;
      tx_data_n     = bus.uart_tx_data;
      wr_en_n       = 1'b0;
      rd_en_n       = 1'b0;
      tx_en_n       = 1'b0;
      err_timeout_n = 1'b0;
      err_overrun_n = 1'b0;
      busy_n        = (nxt_state != S_IDLE);

      unique case (state)
         S_IDLE: begin
            if (bus.uart_rx_valid) begin
               addr_n  = bus.uart_rx_data[ADDR_W-1:0];
               rd_en_n = ~bus.uart_rx_data[7];
            end
         end
         S_WAIT_DATA: begin
            if (bus.uart_rx_valid) begin
               wdata_n = bus.uart_rx_data;
               wr_en_n = 1'b1;
            end else if (expired) begin
               err_timeout_n = 1'b1;
            end
         end
         S_READ_REQ: begin
            if (bus.reg_rd_valid) begin
               tx_data_n = bus.reg_rdata;
            end
         end
         S_READ_WAIT: begin
            if (bus.reg_rd_valid) begin
               tx_data_n = bus.reg_rdata;
            end else if (expired) begin
               err_timeout_n = 1'b1;
            end
         end
         S_TX_SEND: begin
            tx_en_n = ~bus.uart_tx_busy;
         end
         default: ;
      endcase

      // Bytes arriving while an access is in flight are dropped, not queued.
      if (bus.uart_rx_valid && state != S_IDLE && state != S_WAIT_DATA) begin
         err_overrun_n = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state            <= S_IDLE;
         cnt              <= '0;
         bus.reg_addr     <= '0;
         bus.reg_wdata    <= '0;
         bus.reg_wr_en    <= 1'b0;
         bus.reg_rd_en    <= 1'b0;
         bus.uart_tx_en   <= 1'b0;
         bus.uart_tx_data <= '0;
         busy             <= 1'b0;
         err_timeout      <= 1'b0;
         err_overrun      <= 1'b0;
      end else begin
         state            <= nxt_state;
         cnt              <= cnt_n;
         bus.reg_addr     <= addr_n;
         bus.reg_wdata    <= wdata_n;
         bus.reg_wr_en    <= wr_en_n;
         bus.reg_rd_en    <= rd_en_n;
         bus.uart_tx_en   <= tx_en_n;
         bus.uart_tx_data <= tx_data_n;
         busy             <= busy_n;
         err_timeout      <= err_timeout_n;
         err_overrun      <= err_overrun_n;
      end
   end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_ctrl
// Scoreboard bench for uart_reg_ctrl. Stimulus pushes the expected strobe /
// transmit / error events into a queue; a monitor pops and compares whenever
// the DUT raises one. A small register-file stub with selectable read latency
// and a UART TX stub with busy backpressure surround the DUT.
// -----------------------------------------------------------------------------
module tb_uart_reg_ctrl;

   localparam int TIMEOUT = 50;
   localparam int TX_LEN  = 10;
   // Byte spacing shortened so a write's data byte lands inside the timeout.
   localparam int GAP     = 40;

   localparam int K_WR = 0;
   localparam int K_RD = 1;
   localparam int K_TX = 2;
   localparam int K_TO = 3;
   localparam int K_OV = 4;

   typedef struct {
      int         kind;
      logic [7:0] a;
      logic [7:0] d;
   } ev_t;

   logic clk;
   logic resetn;
   logic busy;
   logic err_timeout;
   logic err_overrun;

   int   total;
   int   bad;
   ev_t  exp_q[$];

   int   rd_lat;       // 0,1,2 cycles; 3 = never answer
   logic force_busy;
   logic p1;
   logic p2;
   int   tx_cnt;
   logic [7:0] mem [128];

   uart_reg_ctrl_if #(.ADDR_W(7)) bus ();

   uart_reg_ctrl #(
      .CLK_HZ(50000000),
      .TIMEOUT_CYCLES(TIMEOUT),
      .ADDR_W(7)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus),
      .busy(busy),
      .err_timeout(err_timeout),
      .err_overrun(err_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file stub
   assign bus.reg_rdata    = mem[bus.reg_addr];
   assign bus.reg_rd_valid = (rd_lat == 0 && bus.reg_rd_en) ||
                             (rd_lat == 1 && p1) || (rd_lat == 2 && p2);

   always @(posedge clk) begin
      if (!resetn) begin
         p1 <= 1'b0;
         p2 <= 1'b0;
         for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
         mem[7'h02] <= 8'h22;
         mem[7'h03] <= 8'hC3;
         mem[7'h10] <= 8'h6E;
         mem[7'h33] <= 8'h3C;
      end else begin
         p1 <= bus.reg_rd_en;
         p2 <= p1;
         if (bus.reg_wr_en) mem[bus.reg_addr] <= bus.reg_wdata;
      end
   end

   // UART TX stub: busy rises the cycle after uart_tx_en
   assign bus.uart_tx_busy = force_busy || (tx_cnt != 0);

   always @(posedge clk) begin
      if (!resetn) tx_cnt <= 0;
      else if (bus.uart_tx_en) tx_cnt <= TX_LEN;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
   end

   function automatic string kname(input int k);
      case (k)
         K_WR: return "wr";
         K_RD: return "rd";
         K_TX: return "tx";
         K_TO: return "timeout";
         default: return "overrun";
      endcase
   endfunction

   task automatic expect_ev(input int k, input logic [7:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.a    = a;
      e.d    = d;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input int k, input logic [7:0] a, input logic [7:0] d);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%s at %0t: got a=%02h d=%02h, required no event",
                  kname(k), $time, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.a != a || e.d != d) begin
            bad++;
            $display("FAIL event_%s at %0t: got %s a=%02h d=%02h, required %s a=%02h d=%02h",
                     kname(e.kind), $time, kname(k), a, d, kname(e.kind), e.a, e.d);
         end
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.reg_wr_en)  check_ev(K_WR, {1'b0, bus.reg_addr}, bus.reg_wdata);
         if (bus.reg_rd_en)  check_ev(K_RD, {1'b0, bus.reg_addr}, 8'h00);
         if (bus.uart_tx_en) check_ev(K_TX, 8'h00, bus.uart_tx_data);
         if (err_timeout)    check_ev(K_TO, 8'h00, 8'h00);
         if (err_overrun)    check_ev(K_OV, 8'h00, 8'h00);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.uart_rx_valid = 1'b1;
      bus.uart_rx_data  = b;
      @(posedge clk);
      #1;
      bus.uart_rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 300 && !done; i++) begin
         if (!busy) done = 1'b1;
         else @(negedge clk);
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s_idle: busy still 1 after 300 cycles, required 0", name);
      end
   endtask

   initial begin
      logic [7:0] wd [4];
      wd[0] = 8'hA1;
      wd[1] = 8'hB2;
      wd[2] = 8'hC3;
      wd[3] = 8'hD4;
      total = 0;
      bad   = 0;
      resetn = 1'b0;
      force_busy = 1'b0;
      rd_lat = 2;
      bus.uart_rx_valid = 1'b0;
      bus.uart_rx_data  = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_wr_en", {31'b0, bus.reg_wr_en}, 0);
      chk("rst_rd_en", {31'b0, bus.reg_rd_en}, 0);
      chk("rst_tx_en", {31'b0, bus.uart_tx_en}, 0);
      chk("rst_err", {30'b0, err_timeout, err_overrun}, 0);
      chk("rst_addr", {25'b0, bus.reg_addr}, 0);
      chk("rst_wdata", {24'b0, bus.reg_wdata}, 0);
      chk("rst_tx_data", {24'b0, bus.uart_tx_data}, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Write 0x5A to address 0x01
      expect_ev(K_WR, 8'h01, 8'h5A);
      send_rx(8'h81);
      send_rx(8'h5A);
      @(negedge clk);
      chk("write_strobe_timing", {31'b0, bus.reg_wr_en}, 1);
      wait_idle("write");

      // Read address 0x03, two-cycle register file
      rd_lat = 2;
      expect_ev(K_RD, 8'h03, 8'h00);
      expect_ev(K_TX, 8'h00, 8'hC3);
      send_rx(8'h03);
      @(negedge clk);
      chk("read_strobe_timing", {31'b0, bus.reg_rd_en}, 1);
      wait_idle("read");
      chk("read_tx_busy_clear", {31'b0, bus.uart_tx_busy}, 0);

      // Write timeout, then a read of 0x02 through the zero-latency path
      expect_ev(K_TO, 8'h00, 8'h00);
      send_rx(8'h85);
      wait_idle("write_timeout");
      rd_lat = 0;
      expect_ev(K_RD, 8'h02, 8'h00);
      expect_ev(K_TX, 8'h00, 8'h22);
      send_rx(8'h02);
      wait_idle("read_after_timeout");

      // Read timeout: register file never answers
      rd_lat = 3;
      expect_ev(K_RD, 8'h07, 8'h00);
      expect_ev(K_TO, 8'h00, 8'h00);
      send_rx(8'h07);
      wait_idle("read_timeout");

      // TX backpressure plus an overrun byte during TX_SEND
      rd_lat = 1;
      force_busy = 1'b1;
      expect_ev(K_RD, 8'h10, 8'h00);
      expect_ev(K_OV, 8'h00, 8'h00);
      send_rx(8'h10);
      repeat (5) @(posedge clk);
      send_rx(8'h85);
      @(negedge clk);
      chk("overrun_pulse", {31'b0, err_overrun}, 1);
      repeat (10) @(posedge clk);
      #1;
      expect_ev(K_TX, 8'h00, 8'h6E);
      force_busy = 1'b0;
      wait_idle("backpressure");

      // Reset in the middle of a write
      send_rx(8'h90);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("midreset_busy", {31'b0, busy}, 0);
      rd_lat = 2;
      expect_ev(K_RD, 8'h33, 8'h00);
      expect_ev(K_TX, 8'h00, 8'h3C);
      send_rx(8'h33);
      wait_idle("midreset_read");

      // Back-to-back writes then reads of 0x41..0x44
      for (int i = 0; i < 4; i++) begin
         expect_ev(K_WR, 8'h41 + 8'(i), wd[i]);
         send_rx(8'hC1 + 8'(i));
         repeat (GAP) @(posedge clk);
         send_rx(wd[i]);
         repeat (GAP) @(posedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         expect_ev(K_RD, 8'h41 + 8'(i), 8'h00);
         expect_ev(K_TX, 8'h00, wd[i]);
         send_rx(8'h41 + 8'(i));
         repeat (GAP) @(posedge clk);
      end
      wait_idle("b2b");

      repeat (10) @(negedge clk);
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_%s: got no event, required a=%02h d=%02h",
                  kname(e.kind), e.a, e.d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
